// File: rtl/debug_vjtag_scan_master_pkg.sv
// Shared definitions for the virtual-JTAG scan master: scan state encoding
// and default widths matching the debug-slave tck block (2-bit IR, 38-bit sr).
package debug_vjtag_scan_master_pkg;

  localparam int DEFAULT_IR_WIDTH = 2;
  localparam int DEFAULT_DR_WIDTH = 38;
  localparam int DEFAULT_TCK_DIV  = 4;

  // Wide enough for any half-period length from 1 to 255 clk cycles.
  localparam int TCK_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RESP = 3'd5
  } scan_state_e;

  // True while a scan is in flight and tck has to toggle.
  function automatic logic is_scanning(input scan_state_e s);
    return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) || (s == ST_UDR);
  endfunction

endpackage

// File: rtl/debug_vjtag_scan_master_if.sv
// Command/response handshake bundle between a scan requester (master) and
// the scan master block (slave).
interface debug_vjtag_scan_master_if
  import debug_vjtag_scan_master_pkg::*;
#(
  parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
  parameter int DR_WIDTH = DEFAULT_DR_WIDTH
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_dr,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_dr
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_dr,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_dr
  );

endinterface

// File: rtl/debug_vjtag_tck_gen.sv
// tck generator: while run is high, tck is low for TCK_DIV clk cycles and
// then high for TCK_DIV. fall_pulse/rise_pulse flag the clk edge on which
// tck goes low (period start) or high. When run drops, tck parks low with
// the counter cleared so the next scan starts on a clean period boundary.
module debug_vjtag_tck_gen
  import debug_vjtag_scan_master_pkg::*;
#(
  parameter int TCK_DIV = DEFAULT_TCK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tck,
  output logic fall_pulse,
  output logic rise_pulse
);

  localparam logic [TCK_CNT_WIDTH-1:0] CNT_LAST = TCK_CNT_WIDTH'(TCK_DIV - 1);

  logic [TCK_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     tck_q, tck_d;

  // Count out each half-period and flip tck when it expires.
  always_comb begin
    cnt_d      = cnt_q;
    tck_d      = tck_q;
    fall_pulse = 1'b0;
    rise_pulse = 1'b0;
    if (!run) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      tck_d      = ~tck_q;
      rise_pulse = ~tck_q;
      fall_pulse = tck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Half-period counter and tck level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck = tck_q;

endmodule

// File: rtl/debug_vjtag_scan_master.sv
// Virtual-JTAG scan master: for each accepted command it walks the target
// through UIR (loading ir_in), CDR, DR_WIDTH SDR shift periods (LSB first,
// tdo entering at the top) and UDR, then offers the captured word on the
// response channel until it is taken.
module debug_vjtag_scan_master
  import debug_vjtag_scan_master_pkg::*;
#(
  parameter int IR_WIDTH = DEFAULT_IR_WIDTH,
  parameter int DR_WIDTH = DEFAULT_DR_WIDTH,
  parameter int TCK_DIV  = DEFAULT_TCK_DIV
) (
  input  logic                      clk,
  input  logic                      reset,
  debug_vjtag_scan_master_if.slave  host,
  output logic                      tck,
  output logic                      tdi,
  input  logic                      tdo,
  output logic [IR_WIDTH-1:0]       ir_in,
  input  logic [IR_WIDTH-1:0]       ir_out,
  output logic                      jtag_state_rti,
  output logic                      vs_uir,
  output logic                      vs_cdr,
  output logic                      vs_sdr,
  output logic                      vs_udr
);

  localparam int BIT_CNT_WIDTH = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [BIT_CNT_WIDTH-1:0] BIT_LAST = BIT_CNT_WIDTH'(DR_WIDTH - 1);

  scan_state_e              state_q, state_d;
  logic [DR_WIDTH-1:0]      sr_q, sr_d;
  logic [IR_WIDTH-1:0]      ir_q, ir_d;
  logic                     tdi_q, tdi_d;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

  logic tck_run;
  logic tck_raw;
  logic fall_pulse;
  logic rise_pulse;
  logic cmd_ready_w;
  logic accept;

  // The target's IR readback carries nothing this master needs.
  logic unused_ir_out;
  assign unused_ir_out = ^ir_out;

  assign tck_run = is_scanning(state_q);

  debug_vjtag_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk        (clk),
    .reset      (reset),
    .run        (tck_run),
    .tck        (tck_raw),
    .fall_pulse (fall_pulse),
    .rise_pulse (rise_pulse)
  );

  // In IDLE tck is parked low with the counter cleared, so every IDLE cycle
  // is a period boundary and a command can be taken straight away.
  assign cmd_ready_w = (state_q == ST_IDLE) && !reset;
  assign accept      = cmd_ready_w && host.cmd_valid;

  // Next-state, shifter and tdi: state/tdi move only at period start, tdo
  // is captured only on the tck rising edge.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    ir_d      = ir_q;
    tdi_d     = tdi_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_d    = host.cmd_dr;
          ir_d    = host.cmd_ir;
          tdi_d   = 1'b0;
          state_d = ST_UIR;
        end
      end
      ST_UIR: begin
        if (fall_pulse) begin
          state_d = ST_CDR;
        end
      end
      ST_CDR: begin
        if (fall_pulse) begin
          state_d   = ST_SDR;
          bit_cnt_d = '0;
          tdi_d     = sr_q[0];
        end
      end
      ST_SDR: begin
        if (rise_pulse) begin
          sr_d = {tdo, sr_q[DR_WIDTH-1:1]};
        end
        if (fall_pulse) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_UDR;
            tdi_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tdi_d     = sr_q[0];
          end
        end
      end
      ST_UDR: begin
        if (fall_pulse) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (host.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scan state, shift register, latched IR and tdi registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      ir_q      <= '0;
      tdi_q     <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      ir_q      <= ir_d;
      tdi_q     <= tdi_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Outputs are forced to their idle values for as long as reset is held,
  // including the first reset cycle of an aborted scan.
  assign host.cmd_ready = cmd_ready_w;
  assign host.rsp_valid = !reset && (state_q == ST_RESP);
  assign host.rsp_dr    = reset ? '0 : sr_q;

  assign tck            = tck_raw && !reset;
  assign tdi            = tdi_q && !reset;
  assign ir_in          = reset ? '0 : ir_q;
  assign jtag_state_rti = reset || (state_q == ST_IDLE);
  assign vs_uir         = !reset && (state_q == ST_UIR);
  assign vs_cdr         = !reset && (state_q == ST_CDR);
  assign vs_sdr         = !reset && (state_q == ST_SDR);
  assign vs_udr         = !reset && (state_q == ST_UDR);

endmodule

// File: tb/tb_debug_vjtag_scan_master.sv
// Bench for debug_vjtag_scan_master: directed and randomized scans with
// loopback, tied-high and random tdo sources, a response scoreboard, and
// continuous protocol checks on the target-side signals.
module tb_debug_vjtag_scan_master;
  import debug_vjtag_scan_master_pkg::*;

  localparam int IR_W          = DEFAULT_IR_WIDTH;
  localparam int DR_W          = DEFAULT_DR_WIDTH;
  localparam int TCK_DIV       = 4;
  localparam int PERIOD        = 2 * TCK_DIV;
  localparam int SCAN_CYCLES   = (DR_W + 3) * PERIOD;
  localparam int ACCEPT_BUDGET = 2000;
  localparam int DRAIN_BUDGET  = 3000;

  typedef enum logic [1:0] {TDO_LOOP, TDO_ONES, TDO_RANDOM} tdo_mode_e;
  typedef struct {
    tdo_mode_e       mode;
    logic [DR_W-1:0] word;
  } tdo_cfg_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            tck, tdi, tdo;
  logic [IR_W-1:0] ir_in;
  logic [IR_W-1:0] ir_out = '0;
  logic            rti, vs_uir, vs_cdr, vs_sdr, vs_udr;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DR_W-1:0] exp_q[$];
  tdo_cfg_t        cfg_q[$];
  tdo_cfg_t        cur_cfg = '{mode: TDO_LOOP, word: '0};
  int              idx = 0;
  logic [IR_W-1:0] ir_exp = '0;
  int              stall_left = 0;
  bit              random_ready = 1'b0;

  debug_vjtag_scan_master_if #(.IR_WIDTH(IR_W), .DR_WIDTH(DR_W)) host_if ();

  debug_vjtag_scan_master #(
    .IR_WIDTH (IR_W),
    .DR_WIDTH (DR_W),
    .TCK_DIV  (TCK_DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .host           (host_if),
    .tck            (tck),
    .tdi            (tdi),
    .tdo            (tdo),
    .ir_in          (ir_in),
    .ir_out         (ir_out),
    .jtag_state_rti (rti),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Target model: tdo follows the source chosen for the scan in flight.
  always_comb begin
    tdo = 1'b0;
    case (cur_cfg.mode)
      TDO_LOOP: tdo = tdi;
      TDO_ONES: tdo = 1'b1;
      default:  tdo = (idx < DR_W) ? cur_cfg.word[idx] : 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DR_W-1:0] randDr();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DR_W-1:0];
  endfunction

  // Presents one command, waits for it to be taken, and records what the
  // captured word must be: the tdo samples in shift order.
  task automatic applyStimulus(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                               input tdo_mode_e mode, input logic [DR_W-1:0] word);
    int       waited;
    logic     taken;
    tdo_cfg_t cfg;
    waited = 0;
    @(posedge clk); #1;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_ir    = ir;
    host_if.cmd_dr    = dr;
    @(negedge clk);
    while (!host_if.cmd_ready && waited < ACCEPT_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    taken = host_if.cmd_ready;
    checkOutput("cmd_accept_in_budget", 64'(taken), 64'd1);
    @(posedge clk); #1;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_ir    = '0;
    host_if.cmd_dr    = '0;
    if (taken) begin
      cfg.mode = mode;
      cfg.word = word;
      cfg_q.push_back(cfg);
      case (mode)
        TDO_LOOP: exp_q.push_back(dr);
        TDO_ONES: exp_q.push_back({DR_W{1'b1}});
        default:  exp_q.push_back(word);
      endcase
    end
  endtask

  task automatic waitIdle();
    int waited;
    waited = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !rti) && waited < DRAIN_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_in_budget", 64'(exp_q.size() == 0 && rti), 64'd1);
  endtask

  // Response-side ready: optional stall once a response appears, optional
  // random back-pressure, otherwise always ready.
  initial begin
    host_if.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && host_if.rsp_valid) begin
        host_if.rsp_ready = 1'b0;
        stall_left--;
      end else if (random_ready) begin
        host_if.rsp_ready = 1'($urandom_range(0, 1));
      end else begin
        host_if.rsp_ready = 1'b1;
      end
    end
  end

  // Monitor and scoreboard: samples everything on the falling clk edge.
  initial begin
    logic            prev_tck = 1'b0, prev_tdi = 1'b0, prev_uir = 1'b0;
    logic            prev_cdr = 1'b0, prev_udr = 1'b0, prev_reset = 1'b1;
    logic            prev_rsp_valid = 1'b0, prev_rsp_ready = 1'b0;
    logic [DR_W-1:0] prev_rsp_dr = '0;
    logic [DR_W-1:0] want;
    int              scan_cyc = 0;
    bit              scan_timed = 1'b0;
    int              gap = 0;
    bit              gap_armed = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("reset_outputs",
                    64'({tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti,
                         host_if.cmd_ready, host_if.rsp_valid}),
                    64'({1'b0, 1'b0, {IR_W{1'b0}}, 4'b0000, 1'b1, 1'b0, 1'b0}));
        checkOutput("reset_rsp_dr", 64'(host_if.rsp_dr), 64'd0);
        ir_exp     = '0;
        scan_timed = 1'b0;
        gap_armed  = 1'b0;
      end else begin
        if (gap_armed) gap++;
        if (prev_reset) checkOutput("cmd_ready_after_reset", 64'(host_if.cmd_ready), 64'd1);
        checkOutput("strobes_onehot", 64'($countones({vs_uir, vs_cdr, vs_sdr, vs_udr, rti}) <= 1), 64'd1);
        checkOutput("cmd_ready_only_idle", 64'(host_if.cmd_ready && !rti), 64'd0);
        checkOutput("ir_in_hold", 64'(ir_in), 64'(ir_exp));
        if (tck && prev_tck) checkOutput("tdi_stable_tck_high", 64'(tdi), 64'(prev_tdi));
        if (prev_rsp_valid && !prev_rsp_ready) begin
          checkOutput("rsp_valid_held", 64'(host_if.rsp_valid), 64'd1);
          checkOutput("rsp_dr_held", 64'(host_if.rsp_dr), 64'(prev_rsp_dr));
        end
        if (vs_uir && !prev_uir) begin
          if (gap_armed) checkOutput("b2b_uir_gap_ok", 64'(gap <= PERIOD + 2), 64'd1);
          gap_armed  = 1'b0;
          scan_cyc   = 0;
          scan_timed = 1'b1;
        end else begin
          scan_cyc++;
        end
        if (vs_cdr && !prev_cdr) begin
          if (cfg_q.size() > 0) cur_cfg = cfg_q.pop_front();
          else cur_cfg = '{mode: TDO_LOOP, word: '0};
          idx = 0;
        end
        if (tck && !prev_tck && vs_sdr) idx++;
        if (vs_udr && !prev_udr) checkOutput("sdr_tck_rises", 64'(idx), 64'(DR_W));
        if (host_if.rsp_valid && !prev_rsp_valid && scan_timed) begin
          checkOutput("uir_to_resp_clks", 64'(scan_cyc), 64'(SCAN_CYCLES));
          scan_timed = 1'b0;
        end
        if (host_if.rsp_valid && host_if.rsp_ready) begin
          checkOutput("rsp_has_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checkOutput("rsp_dr", 64'(host_if.rsp_dr), 64'(want));
          end
          gap       = 0;
          gap_armed = host_if.cmd_valid;
        end
        if (host_if.cmd_valid && host_if.cmd_ready) ir_exp = host_if.cmd_ir;
      end
      prev_tck       = tck;
      prev_tdi       = tdi;
      prev_uir       = vs_uir;
      prev_cdr       = vs_cdr;
      prev_udr       = vs_udr;
      prev_reset     = reset;
      prev_rsp_valid = host_if.rsp_valid;
      prev_rsp_ready = host_if.rsp_ready;
      prev_rsp_dr    = host_if.rsp_dr;
    end
  end

  // Hard stop if the run ever wedges.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int waited;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_ir    = '0;
    host_if.cmd_dr    = '0;
    reset             = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] directed: loopback and tdo tied high");
    applyStimulus(2'b10, 38'h2A_5555_AAAA, TDO_LOOP, '0);
    applyStimulus(2'b01, '0, TDO_ONES, '0);
    waitIdle();

    $display("[TB] directed: two queued commands with stalled response");
    stall_left = 10;
    applyStimulus(2'b11, randDr(), TDO_RANDOM, randDr());
    applyStimulus(2'b00, randDr(), TDO_LOOP, '0);
    waitIdle();

    $display("[TB] random commands with random back-pressure");
    random_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      applyStimulus(IR_W'($urandom_range(0, 3)), randDr(),
                    tdo_mode_e'($urandom_range(0, 2)), randDr());
    end
    waitIdle();
    random_ready = 1'b0;

    $display("[TB] reset during SDR bit 17");
    applyStimulus(2'b11, randDr(), TDO_RANDOM, randDr());
    waited = 0;
    @(negedge clk);
    while (!(vs_sdr && idx == 17) && waited < ACCEPT_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("reach_sdr_bit17", 64'(vs_sdr && idx == 17), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    cfg_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      checkOutput("no_udr_after_abort", 64'(vs_udr), 64'd0);
      checkOutput("no_rsp_after_abort", 64'(host_if.rsp_valid), 64'd0);
    end
    applyStimulus(2'b10, 38'h2A_5555_AAAA, TDO_LOOP, '0);
    waitIdle();

    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
